// File: rtl/sip_frame_feeder.sv
// sip_frame_feeder
// Producer end of the SIP parallel-load interface. Upstream spike/Ein frame
// pairs are buffered in a small FIFO. The head frame is held stable on
// parallel_spike_in/parallel_Ein. The next frame is loaded whenever the SIP
// raises flush_spike or flush_Ein. If a request arrives and no frame is
// buffered, a zero frame is presented and a sticky underflow flag is set.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   wr_valid/wr_spike/    upstream frame push (valid/ready handshake)
//   wr_ein/wr_ready
//   flush_spike/flush_Ein SIP consume requests (rising edge = one request)
//   parallel_spike_in/    frame currently presented to the SIP
//   parallel_Ein
//   frame_valid           presented frame is real data (not a starvation zero)
//   underflow             sticky: a request found the FIFO empty
//   frames_sent           frames loaded onto the outputs (wraps)
module sip_frame_feeder #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [N-1:0]  wr_spike,
  input  logic [N-1:0]  wr_ein,
  output logic          wr_ready,
  input  logic          flush_spike,
  input  logic          flush_Ein,
  output logic [N-1:0]  parallel_spike_in,
  output logic [N-1:0]  parallel_Ein,
  output logic          frame_valid,
  output logic          underflow,
  output logic [CW-1:0] frames_sent
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] STARVED = 2'd2;

  logic [N-1:0]  spike_mem_q [DEPTH];
  logic [N-1:0]  ein_mem_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic          flush_spike_q, flush_ein_q;
  logic [N-1:0]  spike_q, ein_q;
  logic          fvalid_q, uflow_q;
  logic [CW-1:0] sent_q;

  logic push, pop, starve, set_uf, empty, req;

  // Ready and empty come from the registered count only, so a frame pushed
  // this cycle cannot be popped until the next one (no bypass path).
  assign wr_ready = (cnt_q < (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = wr_valid & wr_ready;

  // One request per rising edge of the OR of both flush lines; an edge on
  // one line while the other is already high is not a new request.
  assign req = (flush_spike | flush_Ein) & ~(flush_spike_q | flush_ein_q);

  always_comb begin
    pop     = 1'b0;
    starve  = 1'b0;
    set_uf  = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // First frame loads without a request.
        if (!empty) begin
          pop     = 1'b1;
          state_d = PRESENT;
        end else if (req) begin
          set_uf  = 1'b1;
        end
      end
      PRESENT: begin
        if (req) begin
          if (!empty) begin
            pop     = 1'b1;
          end else begin
            starve  = 1'b1;
            set_uf  = 1'b1;
            state_d = STARVED;
          end
        end
      end
      STARVED: begin
        // Recover as soon as data arrives; the SIP already asked for it.
        if (!empty) begin
          pop     = 1'b1;
          state_d = PRESENT;
        end else if (req) begin
          set_uf  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      spike_mem_q[wr_ptr_q] <= wr_spike;
      ein_mem_q[wr_ptr_q]   <= wr_ein;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      flush_spike_q <= 1'b0;
      flush_ein_q   <= 1'b0;
      spike_q       <= '0;
      ein_q         <= '0;
      fvalid_q      <= 1'b0;
      uflow_q       <= 1'b0;
      sent_q        <= '0;
    end else begin
      flush_spike_q <= flush_spike;
      flush_ein_q   <= flush_Ein;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        spike_q  <= spike_mem_q[rd_ptr_q];
        ein_q    <= ein_mem_q[rd_ptr_q];
        fvalid_q <= 1'b1;
        sent_q   <= sent_q + CW'(1);
      end else if (starve) begin
        spike_q  <= '0;
        ein_q    <= '0;
        fvalid_q <= 1'b0;
      end
      if (set_uf) uflow_q <= 1'b1;
    end
  end

  assign parallel_spike_in = spike_q;
  assign parallel_Ein      = ein_q;
  assign frame_valid       = fvalid_q;
  assign underflow         = uflow_q;
  assign frames_sent       = sent_q;

endmodule

// File: tb/tb_sip_frame_feeder.sv
module tb_sip_frame_feeder;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [15:0] wr_spike, wr_ein;
  logic        wr_ready;
  logic        flush_spike, flush_Ein;
  logic [15:0] parallel_spike_in, parallel_Ein;
  logic        frame_valid, underflow;
  logic [7:0]  frames_sent;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb[$];      // expected frames {spike, ein} in FIFO order
  logic [31:0] exp_f;
  logic [7:0]  exp_sent;

  sip_frame_feeder #(.N(16), .DEPTH(4), .CW(8)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_spike(wr_spike), .wr_ein(wr_ein), .wr_ready(wr_ready),
    .flush_spike(flush_spike), .flush_Ein(flush_Ein),
    .parallel_spike_in(parallel_spike_in), .parallel_Ein(parallel_Ein),
    .frame_valid(frame_valid), .underflow(underflow), .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one frame for one edge; it enters the scoreboard only if accepted.
  task automatic push_frame(input logic [15:0] s, input logic [15:0] e);
    wr_valid = 1'b1; wr_spike = s; wr_ein = e;
    if (wr_ready) sb.push_back({s, e});
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 0; wr_spike = 0; wr_ein = 0; flush_spike = 0; flush_Ein = 0;
    tick(); tick();
    reset = 1'b0;
    exp_sent = 0;
    total++; if ({parallel_spike_in, parallel_Ein} !== 32'h0) $display("FAIL reset_out: got %h/%h want 0/0", parallel_spike_in, parallel_Ein); else passed++;
    total++; if ({frame_valid, underflow, wr_ready} !== 3'b001) $display("FAIL reset_flags: got fv=%b uf=%b rdy=%b want 0 0 1", frame_valid, underflow, wr_ready); else passed++;
    total++; if (frames_sent !== 8'd0) $display("FAIL reset_sent: got %0d want 0", frames_sent); else passed++;
  endtask

  task automatic test_first_frame();
    push_frame(16'hAAAA, 16'hFFFF);
    total++; if (frame_valid !== 1'b0) $display("FAIL first_early: got fv=%b want 0", frame_valid); else passed++;
    tick();
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f) $display("FAIL first_load: got %h/%h want %h", parallel_spike_in, parallel_Ein, exp_f); else passed++;
    total++; if (frame_valid !== 1'b1 || frames_sent !== exp_sent) $display("FAIL first_fv_sent: got fv=%b sent=%0d want 1 %0d", frame_valid, frames_sent, exp_sent); else passed++;
  endtask

  task automatic test_fill();
    push_frame(16'hD55D, ~16'hD55D);
    push_frame(16'h0001, ~16'h0001);
    push_frame(16'h0002, ~16'h0002);
    push_frame(16'h0003, ~16'h0003);
    total++; if (wr_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", wr_ready); else passed++;
    push_frame(16'hBEEF, 16'hBEEF);  // refused: not added to scoreboard
    total++; if (parallel_spike_in !== 16'hAAAA || frames_sent !== exp_sent) $display("FAIL full_hold: got %h sent=%0d want aaaa %0d", parallel_spike_in, frames_sent, exp_sent); else passed++;
  endtask

  task automatic test_single_advance();
    flush_spike = 1'b1;
    tick();
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f) $display("FAIL adv_load: got %h/%h want %h", parallel_spike_in, parallel_Ein, exp_f); else passed++;
    total++; if (wr_ready !== 1'b1) $display("FAIL adv_ready: got %b want 1", wr_ready); else passed++;
    tick(); tick();
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frames_sent !== exp_sent) $display("FAIL adv_held: got %h sent=%0d want %h %0d", parallel_spike_in, frames_sent, exp_f[31:16], exp_sent); else passed++;
    flush_spike = 1'b0;
    tick();
  endtask

  task automatic test_push_pop_same();
    flush_spike = 1'b1;
    push_frame(16'h0005, 16'hFFFA);
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f) $display("FAIL pp_load: got %h/%h want %h", parallel_spike_in, parallel_Ein, exp_f); else passed++;
    total++; if (wr_ready !== 1'b1 || frames_sent !== exp_sent) $display("FAIL pp_count: got rdy=%b sent=%0d want 1 %0d", wr_ready, frames_sent, exp_sent); else passed++;
    flush_spike = 1'b0;
    tick();
  endtask

  task automatic test_coincident();
    flush_spike = 1'b1; flush_Ein = 1'b1;
    tick();
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frames_sent !== exp_sent) $display("FAIL coin_load: got %h sent=%0d want %h %0d", parallel_spike_in, frames_sent, exp_f[31:16], exp_sent); else passed++;
    tick();
    flush_Ein = 1'b0;
    tick();
    flush_Ein = 1'b1;  // rises while flush_spike still high
    tick();
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frames_sent !== exp_sent) $display("FAIL coin_noadv: got %h sent=%0d want %h %0d", parallel_spike_in, frames_sent, exp_f[31:16], exp_sent); else passed++;
    flush_spike = 1'b0; flush_Ein = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      push_frame(16'($urandom), 16'($urandom));
      if (i[0]) flush_Ein = 1'b1; else flush_spike = 1'b1;
      tick();
      exp_f = sb.pop_front(); exp_sent++;
      total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frames_sent !== exp_sent) $display("FAIL stream_%0d: got %h/%h sent=%0d want %h %0d", i, parallel_spike_in, parallel_Ein, frames_sent, exp_f, exp_sent); else passed++;
      flush_spike = 1'b0; flush_Ein = 1'b0;
      tick();
    end
  endtask

  task automatic test_starve();
    while (sb.size() > 0) begin
      flush_spike = 1'b1; tick();
      exp_f = sb.pop_front(); exp_sent++;
      total++; if ({parallel_spike_in, parallel_Ein} !== exp_f) $display("FAIL drain: got %h/%h want %h", parallel_spike_in, parallel_Ein, exp_f); else passed++;
      flush_spike = 1'b0; tick();
    end
    total++; if (underflow !== 1'b0) $display("FAIL uf_early: got %b want 0", underflow); else passed++;
    flush_spike = 1'b1; tick();
    total++; if ({parallel_spike_in, parallel_Ein} !== 32'h0 || frame_valid !== 1'b0 || underflow !== 1'b1) $display("FAIL starve: got %h/%h fv=%b uf=%b want 0/0 0 1", parallel_spike_in, parallel_Ein, frame_valid, underflow); else passed++;
    flush_spike = 1'b0; tick();
    push_frame(16'h1234, 16'hAAAA);
    tick();
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frame_valid !== 1'b1 || underflow !== 1'b1 || frames_sent !== exp_sent) $display("FAIL recover: got %h/%h fv=%b uf=%b sent=%0d want %h 1 1 %0d", parallel_spike_in, parallel_Ein, frame_valid, underflow, frames_sent, exp_f, exp_sent); else passed++;
  endtask

  task automatic test_push_req_race();
    // FIFO empty in PRESENT: request and push on the same edge starve first.
    flush_spike = 1'b1;
    push_frame(16'h00C0, 16'h0C00);
    total++; if (frame_valid !== 1'b0 || parallel_spike_in !== 16'h0) $display("FAIL race_starve: got fv=%b %h want 0 0000", frame_valid, parallel_spike_in); else passed++;
    tick();
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frame_valid !== 1'b1) $display("FAIL race_load: got %h/%h fv=%b want %h 1", parallel_spike_in, parallel_Ein, frame_valid, exp_f); else passed++;
    flush_spike = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    push_frame(16'h0101, 16'h1010);
    push_frame(16'h0202, 16'h2020);
    push_frame(16'h0303, 16'h3030);
    reset = 1'b1; tick(); reset = 1'b0;
    sb.delete(); exp_sent = 0;
    total++; if ({parallel_spike_in, parallel_Ein} !== 32'h0 || frame_valid !== 1'b0 || underflow !== 1'b0 || frames_sent !== 8'd0 || wr_ready !== 1'b1) $display("FAIL mid_reset: got %h/%h fv=%b uf=%b sent=%0d rdy=%b want 0/0 0 0 0 1", parallel_spike_in, parallel_Ein, frame_valid, underflow, frames_sent, wr_ready); else passed++;
    tick();
    total++; if (frame_valid !== 1'b0) $display("FAIL mid_discard: got fv=%b want 0", frame_valid); else passed++;
    flush_Ein = 1'b1; tick();
    total++; if (underflow !== 1'b1 || frame_valid !== 1'b0) $display("FAIL idle_uf: got uf=%b fv=%b want 1 0", underflow, frame_valid); else passed++;
    flush_Ein = 1'b0; tick();
    push_frame(16'h5A5A, 16'hA5A5);
    tick();
    exp_f = sb.pop_front(); exp_sent++;
    total++; if ({parallel_spike_in, parallel_Ein} !== exp_f || frame_valid !== 1'b1 || frames_sent !== exp_sent) $display("FAIL mid_reload: got %h/%h fv=%b sent=%0d want %h 1 %0d", parallel_spike_in, parallel_Ein, frame_valid, frames_sent, exp_f, exp_sent); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_fill();
    test_single_advance();
    test_push_pop_same();
    test_coincident();
    test_stream();
    test_starve();
    test_push_req_race();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sip_frame_feeder.md
Name: sip_frame_feeder

Overview:
- Producer end of the Synaptic_Input_Processor (SIP) parallel-load interface.
- Buffers 16-bit spike/Ein frame pairs from upstream (spike router or external stimulus) in a small FIFO.
- Holds the current frame stable on parallel_spike_in/parallel_Ein.
- Advances to the next frame whenever the SIP requests new data by raising flush_spike or flush_Ein.
- Flags starvation when the SIP requests a frame and none is available.

Parameters:
- N, 16, synapse count; width of spike and Ein words.
- DEPTH, 4, FIFO depth in frames; power of 2, minimum 2.
- CW, 8, width of the frames-delivered counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  upstream frame valid
- wr_spike  in  N  upstream spike word
- wr_ein  in  N  upstream excitatory/inhibitory select word (1 = excitatory)
- wr_ready  out  1  FIFO can accept a frame
- flush_spike  in  1  SIP request: spike word consumed
- flush_Ein  in  1  SIP request: Ein word consumed
- parallel_spike_in  out  N  frame presented to SIP
- parallel_Ein  out  N  Ein word presented to SIP
- frame_valid  out  1  presented frame is real data, not a starvation zero frame
- underflow  out  1  sticky: a request arrived while the FIFO was empty
- frames_sent  out  CW  count of frames loaded onto the outputs

Behaviour:
- Reset (synchronous, active-high, single-cycle effect):
  - FIFO pointers and count cleared; state IDLE.
  - parallel_spike_in = 0, parallel_Ein = 0, frame_valid = 0, underflow = 0, frames_sent = 0.
  - flush edge registers cleared to 0.
  - Reset mid-operation discards all buffered frames; there is no partial recovery.
- Write handshake:
  - wr_ready = (count < DEPTH); it depends only on the registered count.
  - A push occurs when wr_valid && wr_ready at a clock edge.
  - A pop in the same cycle does not raise wr_ready. There is no bypass.
  - A pushed frame becomes poppable on the following cycle.
- Request detection:
  - req = (flush_spike | flush_Ein) & ~(flush_spike_d | flush_Ein_d), where the _d signals are the previous-cycle samples.
  - Coincident rising edges count as one request.
  - A level held high produces only one request.
  - A rising edge of one flush input while the other is already high is not a new request.
- State machine (registered outputs; a load at edge T is visible in cycle T+1):
  - IDLE (after reset, nothing presented):
    - FIFO non-empty -> pop head, load outputs, frame_valid = 1, frames_sent++, go to PRESENT. No request is needed for the first frame.
    - req seen while empty -> underflow = 1, stay in IDLE.
  - PRESENT (outputs held stable):
    - req and FIFO non-empty -> pop and load the next frame, frames_sent++, stay in PRESENT.
    - req and FIFO empty -> outputs = 0, frame_valid = 0, underflow = 1, go to STARVED.
  - STARVED (zero frame presented):
    - FIFO non-empty -> pop and load immediately without waiting for a request, frame_valid = 1, frames_sent++, go to PRESENT.
    - Further req while empty -> underflow stays 1, no other effect.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; the popped frame is the old head.
  - Push into an empty FIFO in the same cycle as req: the request starves (no bypass). The pushed frame loads on the next cycle.
- Arithmetic and sticky flags:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
  - frames_sent wraps modulo 2^CW.
  - underflow clears only on reset.
- Outputs never change in a cycle without a load or starvation event.

Test Plan:
- Reset, then push 16'hAAAA/16'hFFFF -> outputs show AAAA/FFFF two cycles after the push, frame_valid = 1, frames_sent = 1, no flush needed.
- Push 4 frames (spike 16'hD55D, 16'h0001, 16'h0002, 16'h0003), then pulse flush_spike once -> outputs change to the next frame one cycle after the rising edge; holding flush_spike high 3 cycles advances only once; frames_sent increments by exactly 1 per pulse.
- Fill the FIFO to DEPTH -> wr_ready = 0; a further wr_valid is not accepted. Pop with one req -> wr_ready = 1 next cycle; a push and pop in the same cycle keep count unchanged.
- flush_spike and flush_Ein rise in the same cycle -> single advance; flush_Ein rising while flush_spike is already high -> no advance.
- Drain the FIFO, then raise req -> outputs 0, frame_valid = 0, underflow = 1. Push 16'h1234/16'hAAAA -> loaded without a request, frame_valid = 1, underflow stays 1.
- Assert reset while in PRESENT with 3 frames buffered -> all outputs 0, wr_ready = 1. The next push loads into IDLE normally.
